// File: rtl/session_manager.sv
// Session supervisor between authentication and game control: latches the player on
// login, runs inactivity and guest session timers, warns, and requests logout on expiry.
module session_manager #(
   parameter int TICK_DIV     = 50_000_000,
   parameter int IDLE_TIMEOUT = 60,
   parameter int GUEST_LIMIT  = 120,
   parameter int WARN_S       = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       LoggedIn,
   input  logic       LoggedOut,
   input  logic       isGuest,
   input  logic [4:0] PlayerAddress,
   input  logic       Activity,
   input  logic       LogoutButton,
   output logic       LogoutCommand,
   output logic       SessionActive,
   output logic [4:0] SessionAddress,
   output logic       SessionGuest,
   output logic       Warning,
   output logic [7:0] SecondsLeft
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0]    IDLE_LIM  = 8'(IDLE_TIMEOUT);
   localparam logic [7:0]    GUEST_LIM = 8'(GUEST_LIMIT);
   localparam logic [7:0]    WARN_LIM  = 8'(WARN_S);
   localparam logic [7:0]    NO_LIMIT  = 8'd255;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVE,
      S_WARN,
      S_LOGOUT,
      S_WAIT_OUT
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    idle_cnt_q, idle_cnt_d;
   logic [7:0]    sess_cnt_q, sess_cnt_d;
   logic          logout_cmd_q, logout_cmd_d;
   logic          active_q, active_d;
   logic [4:0]    addr_q, addr_d;
   logic          guest_q, guest_d;
   logic          warn_q, warn_d;
   logic [7:0]    left_q, left_d;

   logic          tick;
   logic [7:0]    idle_nx, sess_nx, rem_idle, rem_sess, left_nx;

   function automatic logic [7:0] sat_inc(input logic [7:0] x);
      return (x == 8'hFF) ? x : x + 8'd1;
   endfunction

   function automatic logic [7:0] remaining(input logic [7:0] limit, input logic [7:0] cnt);
      return (cnt >= limit) ? 8'd0 : limit - cnt;
   endfunction

   function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   always_comb begin
      tick     = (presc_q == PRESC_MAX);
      // Activity clears the idle count even when it lands on a tick.
      idle_nx  = Activity ? 8'd0 : (tick ? sat_inc(idle_cnt_q) : idle_cnt_q);
      sess_nx  = (tick && guest_q) ? sat_inc(sess_cnt_q) : sess_cnt_q;
      rem_idle = remaining(IDLE_LIM, idle_nx);
      rem_sess = guest_q ? remaining(GUEST_LIM, sess_nx) : NO_LIMIT;
      left_nx  = min8(rem_idle, rem_sess);

      state_d      = state_q;
      presc_d      = presc_q;
      idle_cnt_d   = idle_cnt_q;
      sess_cnt_d   = sess_cnt_q;
      logout_cmd_d = 1'b0;
      active_d     = active_q;
      addr_d       = addr_q;
      guest_d      = guest_q;
      warn_d       = warn_q;
      left_d       = left_q;

      case (state_q)
         S_IDLE: begin
            if (LoggedIn) begin
               state_d    = S_ACTIVE;
               addr_d     = PlayerAddress;
               guest_d    = isGuest;
               presc_d    = '0;
               idle_cnt_d = 8'd0;
               sess_cnt_d = 8'd0;
               active_d   = 1'b1;
               warn_d     = 1'b0;
               left_d     = min8(IDLE_LIM, isGuest ? GUEST_LIM : NO_LIMIT);
            end
         end

         S_ACTIVE, S_WARN: begin
            if (!LoggedIn) begin
               state_d    = S_IDLE;
               presc_d    = '0;
               idle_cnt_d = 8'd0;
               sess_cnt_d = 8'd0;
               active_d   = 1'b0;
               addr_d     = 5'd0;
               guest_d    = 1'b0;
               warn_d     = 1'b0;
               left_d     = 8'd0;
            end else if (LogoutButton || (left_nx == 8'd0)) begin
               state_d      = S_LOGOUT;
               logout_cmd_d = 1'b1;
               active_d     = 1'b0;
               warn_d       = 1'b0;
               left_d       = 8'd0;
            end else begin
               presc_d    = tick ? '0 : presc_q + 1'b1;
               idle_cnt_d = idle_nx;
               sess_cnt_d = sess_nx;
               left_d     = left_nx;
               // One comparison covers both entering and leaving the warning window.
               warn_d     = (left_nx <= WARN_LIM);
               state_d    = (left_nx <= WARN_LIM) ? S_WARN : S_ACTIVE;
            end
         end

         S_LOGOUT: begin
            state_d = S_WAIT_OUT;
         end

         S_WAIT_OUT: begin
            if (LoggedOut || !LoggedIn) begin
               state_d    = S_IDLE;
               presc_d    = '0;
               idle_cnt_d = 8'd0;
               sess_cnt_d = 8'd0;
               active_d   = 1'b0;
               addr_d     = 5'd0;
               guest_d    = 1'b0;
               warn_d     = 1'b0;
               left_d     = 8'd0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         presc_q      <= '0;
         idle_cnt_q   <= 8'd0;
         sess_cnt_q   <= 8'd0;
         logout_cmd_q <= 1'b0;
         active_q     <= 1'b0;
         addr_q       <= 5'd0;
         guest_q      <= 1'b0;
         warn_q       <= 1'b0;
         left_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         idle_cnt_q   <= idle_cnt_d;
         sess_cnt_q   <= sess_cnt_d;
         logout_cmd_q <= logout_cmd_d;
         active_q     <= active_d;
         addr_q       <= addr_d;
         guest_q      <= guest_d;
         warn_q       <= warn_d;
         left_q       <= left_d;
      end
   end

   assign LogoutCommand  = logout_cmd_q;
   assign SessionActive  = active_q;
   assign SessionAddress = addr_q;
   assign SessionGuest   = guest_q;
   assign Warning        = warn_q;
   assign SecondsLeft    = left_q;

endmodule

// File: tb/tb_session_manager.sv
// Scoreboard bench for session_manager: every change of the output bundle is matched
// against the next hand-computed expected bundle queued by the stimulus.
module tb_session_manager;

   logic       clk;
   logic       rst;
   logic       LoggedIn, LoggedOut, isGuest, Activity, LogoutButton;
   logic [4:0] PlayerAddress;
   logic       LogoutCommand, SessionActive, SessionGuest, Warning;
   logic [4:0] SessionAddress;
   logic [7:0] SecondsLeft;

   int checks   = 0;
   int failures = 0;

   logic [16:0] exp_q[$];
   string       name_q[$];

   session_manager #(
      .TICK_DIV(4), .IDLE_TIMEOUT(6), .GUEST_LIMIT(10), .WARN_S(2)
   ) dut (
      .clk(clk), .rst(rst),
      .LoggedIn(LoggedIn), .LoggedOut(LoggedOut), .isGuest(isGuest),
      .PlayerAddress(PlayerAddress), .Activity(Activity), .LogoutButton(LogoutButton),
      .LogoutCommand(LogoutCommand), .SessionActive(SessionActive),
      .SessionAddress(SessionAddress), .SessionGuest(SessionGuest),
      .Warning(Warning), .SecondsLeft(SecondsLeft)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [16:0] tup(input logic cmd, input logic act, input logic [4:0] addr,
                                       input logic g, input logic w, input logic [7:0] sl);
      return {cmd, act, addr, g, w, sl};
   endfunction

   function automatic logic [16:0] outs();
      return {LogoutCommand, SessionActive, SessionAddress, SessionGuest, Warning, SecondsLeft};
   endfunction

   task automatic push(input string nm, input logic [16:0] t);
      exp_q.push_back(t);
      name_q.push_back(nm);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: samples just after each falling clock or reset edge.
   initial begin : monitor
      logic [16:0] prev, cur, e;
      string nm;
      prev = '0;
      forever begin
         @(negedge clk or negedge rst);
         #1;
         cur = outs();
         if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change: got %h required no change from %h", cur, prev);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (cur !== e) begin
                  failures++;
                  $display("FAIL %s: got %h required %h", nm, cur, e);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin : stim
      rst = 1'b0;
      LoggedIn = 0; LoggedOut = 0; isGuest = 0; Activity = 0; LogoutButton = 0;
      PlayerAddress = 5'd0;
      #3;
      checks++;
      if (outs() !== 17'd0) begin
         failures++;
         $display("FAIL reset_state: got %h required %h", outs(), 17'd0);
      end
      cyc(2);
      rst = 1'b1;
      cyc(2);

      // 1: non-guest idle countdown to forced logout
      push("t1_login", tup(0, 1, 9, 0, 0, 6));
      push("t1_sl5", tup(0, 1, 9, 0, 0, 5));
      push("t1_sl4", tup(0, 1, 9, 0, 0, 4));
      push("t1_sl3", tup(0, 1, 9, 0, 0, 3));
      push("t1_warn2", tup(0, 1, 9, 0, 1, 2));
      push("t1_warn1", tup(0, 1, 9, 0, 1, 1));
      push("t1_logout", tup(1, 0, 9, 0, 0, 0));
      push("t1_wait_out", tup(0, 0, 9, 0, 0, 0));
      push("t1_idle", tup(0, 0, 0, 0, 0, 0));
      isGuest = 0; PlayerAddress = 5'd9; LoggedIn = 1;
      cyc(30);
      LoggedOut = 1; LoggedIn = 0;
      cyc(1);
      LoggedOut = 0;
      cyc(2);

      // 2: activity leaves WARN; activity on a tick still restores the full timeout
      push("t2_login", tup(0, 1, 3, 0, 0, 6));
      push("t2_sl5", tup(0, 1, 3, 0, 0, 5));
      push("t2_sl4", tup(0, 1, 3, 0, 0, 4));
      push("t2_sl3", tup(0, 1, 3, 0, 0, 3));
      push("t2_warn2", tup(0, 1, 3, 0, 1, 2));
      push("t2_act_exit_warn", tup(0, 1, 3, 0, 0, 6));
      push("t2_sl5b", tup(0, 1, 3, 0, 0, 5));
      push("t2_sl4b", tup(0, 1, 3, 0, 0, 4));
      push("t2_act_on_tick", tup(0, 1, 3, 0, 0, 6));
      push("t2_drop_idle", tup(0, 0, 0, 0, 0, 0));
      isGuest = 0; PlayerAddress = 5'd3; LoggedIn = 1;
      cyc(17);
      Activity = 1; cyc(1); Activity = 0;
      cyc(10);
      Activity = 1; cyc(1); Activity = 0;
      cyc(2);
      LoggedIn = 0;
      cyc(3);

      // 3: guest with activity every tick runs out on the session limit
      push("t3_login", tup(0, 1, 21, 1, 0, 6));
      push("t3_sl5", tup(0, 1, 21, 1, 0, 5));
      push("t3_sl4", tup(0, 1, 21, 1, 0, 4));
      push("t3_sl3", tup(0, 1, 21, 1, 0, 3));
      push("t3_warn2", tup(0, 1, 21, 1, 1, 2));
      push("t3_warn1_despite_act", tup(0, 1, 21, 1, 1, 1));
      push("t3_logout", tup(1, 0, 21, 1, 0, 0));
      push("t3_wait_out", tup(0, 0, 21, 1, 0, 0));
      push("t3_idle", tup(0, 0, 0, 0, 0, 0));
      isGuest = 1; PlayerAddress = 5'd21; LoggedIn = 1;
      cyc(4);
      for (int j = 0; j < 10; j++) begin
         Activity = 1; cyc(1); Activity = 0; cyc(3);
      end
      cyc(2);
      LoggedOut = 1; LoggedIn = 0;
      cyc(1);
      LoggedOut = 0;
      cyc(2);

      // 4: logout button beats activity; single pulse while waiting for LoggedOut
      push("t4_login", tup(0, 1, 12, 0, 0, 6));
      push("t4_logout", tup(1, 0, 12, 0, 0, 0));
      push("t4_wait_out", tup(0, 0, 12, 0, 0, 0));
      push("t4_idle", tup(0, 0, 0, 0, 0, 0));
      isGuest = 0; PlayerAddress = 5'd12; LoggedIn = 1;
      cyc(2);
      LogoutButton = 1; Activity = 1;
      cyc(1);
      LogoutButton = 0; Activity = 0;
      cyc(20);
      LoggedOut = 1; LoggedIn = 0;
      cyc(1);
      LoggedOut = 0;
      cyc(2);

      // 5: authentication stage drops LoggedIn mid-session
      push("t5_login", tup(0, 1, 7, 1, 0, 6));
      push("t5_drop_idle", tup(0, 0, 0, 0, 0, 0));
      isGuest = 1; PlayerAddress = 5'd7; LoggedIn = 1;
      cyc(3);
      LoggedIn = 0;
      cyc(3);

      // 6: asynchronous reset in WARN, then a fresh session
      push("t6_login", tup(0, 1, 30, 0, 0, 6));
      push("t6_sl5", tup(0, 1, 30, 0, 0, 5));
      push("t6_sl4", tup(0, 1, 30, 0, 0, 4));
      push("t6_sl3", tup(0, 1, 30, 0, 0, 3));
      push("t6_warn2", tup(0, 1, 30, 0, 1, 2));
      push("t6_reset", tup(0, 0, 0, 0, 0, 0));
      push("t6_relogin", tup(0, 1, 30, 0, 0, 6));
      push("t6_final_idle", tup(0, 0, 0, 0, 0, 0));
      isGuest = 0; PlayerAddress = 5'd30; LoggedIn = 1;
      cyc(18);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (outs() !== 17'd0) begin
         failures++;
         $display("FAIL t6_async_reset: got %h required %h", outs(), 17'd0);
      end
      cyc(2);
      rst = 1'b1;
      cyc(3);
      LoggedIn = 0;
      cyc(4);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_expected: got %0d outstanding required 0 (next %s)",
                  exp_q.size(), name_q[0]);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
